// File: rtl/line_adapter_pkg.sv
// Shared types and geometry helpers for the cache-line <-> memory-burst adapter.
// Modules derive their own BEATS / CNT_W / OFFSET_W from their parameters via these functions.
package line_adapter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_t;

  function automatic int beats_of(input int line_w, input int beat_w);
    return line_w / beat_w;
  endfunction

  function automatic int cnt_w_of(input int line_w, input int beat_w);
    return $clog2(line_w / beat_w);
  endfunction

  function automatic int offset_w_of(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  localparam int DEF_LINE_W   = 256;
  localparam int DEF_BEAT_W   = 64;
  localparam int DEF_BEATS    = beats_of(DEF_LINE_W, DEF_BEAT_W);
  localparam int DEF_CNT_W    = cnt_w_of(DEF_LINE_W, DEF_BEAT_W);
  localparam int DEF_OFFSET_W = offset_w_of(DEF_LINE_W);

endpackage

// File: rtl/line_beat_buffer.sv
// Line-wide register organised as BEATS beats: full-line load, single-beat write, beat read mux.
// line_next exposes the value the register takes at the next edge, so a completing fill can be captured whole.
module line_beat_buffer #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              load_en,
  input  logic [LINE_W-1:0] load_line,
  input  logic              beat_we,
  input  logic [CNT_W-1:0]  beat_idx,
  input  logic [BEAT_W-1:0] beat_data,
  output logic [BEAT_W-1:0] beat_q,
  output logic [LINE_W-1:0] line_next
);
  localparam int BEATS = LINE_W / BEAT_W;

  logic [BEATS-1:0][BEAT_W-1:0] beats_q;
  logic [BEATS-1:0][BEAT_W-1:0] beats_next;

  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_beat
      logic [BEAT_W-1:0] beat_reg;
      logic [BEAT_W-1:0] beat_next;

      always_comb begin
        beat_next = beat_reg;
        if (load_en)
          beat_next = load_line[gi*BEAT_W +: BEAT_W];
        else if (beat_we && (beat_idx == CNT_W'(gi)))
          beat_next = beat_data;
      end

      always_ff @(posedge clk) begin
        if (srst) beat_reg <= '0;
        else      beat_reg <= beat_next;
      end

      assign beats_q[gi]    = beat_reg;
      assign beats_next[gi] = beat_next;
    end
  endgenerate

  assign beat_q    = beats_q[beat_idx];
  assign line_next = beats_next;

endmodule

// File: rtl/line_burst_adapter.sv
// Converts one cache-line request into a BEATS-long memory burst (fill or writeback).
// The beat buffer is shared by both directions; line_o is a separate register that only fills update.
module line_burst_adapter
  import line_adapter_pkg::*;
#(
  parameter int LINE_W    = 256,
  parameter int BEAT_W    = 64,
  parameter int ADDR_W    = 32,
  parameter int INCR_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  output logic              resp_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  output logic [BEAT_W-1:0] burst_o,
  input  logic [BEAT_W-1:0] burst_i,
  input  logic              resp_i
);
  localparam int BEATS      = beats_of(LINE_W, BEAT_W);
  localparam int CNT_W      = cnt_w_of(LINE_W, BEAT_W);
  localparam int OFFSET_W   = offset_w_of(LINE_W);
  localparam int BEAT_BYTES = BEAT_W / 8;
  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((64'd1 << OFFSET_W) - 64'd1);
  localparam logic [CNT_W-1:0]  LAST_BEAT   = CNT_W'(BEATS - 1);

  generate
    if ((LINE_W % BEAT_W) != 0) begin : g_bad_multiple
      $error("line_burst_adapter: LINE_W must be a multiple of BEAT_W");
    end
    if (!is_pow2(BEATS) || (BEATS < 2)) begin : g_bad_beats
      $error("line_burst_adapter: LINE_W/BEAT_W must be a power of 2 and at least 2");
    end
    if ((BEAT_W % 8) != 0) begin : g_bad_beat_bytes
      $error("line_burst_adapter: BEAT_W must be a whole number of bytes");
    end
  endgenerate

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              read_reg;
  logic              write_reg;
  logic              resp_reg;
  logic [LINE_W-1:0] line_reg;

  logic [ADDR_W-1:0] aligned_addr;
  logic [ADDR_W-1:0] beat_addr;
  logic [BEAT_W-1:0] beat_q;
  logic [LINE_W-1:0] fill_line;
  logic              load_en;
  logic              beat_we;

  assign aligned_addr = address_i & ~OFFSET_MASK;
  assign beat_addr    = (INCR_ADDR != 0) ? addr_reg + ADDR_W'(BEAT_BYTES) : addr_reg;
  assign load_en      = (state_reg == IDLE) && write_i;
  assign beat_we      = (state_reg == RD_BURST) && resp_i;

  line_beat_buffer #(
    .LINE_W (LINE_W),
    .BEAT_W (BEAT_W),
    .CNT_W  (CNT_W)
  ) u_buffer (
    .clk       (clk),
    .srst      (rst),
    .load_en   (load_en),
    .load_line (line_i),
    .beat_we   (beat_we),
    .beat_idx  (cnt_reg),
    .beat_data (burst_i),
    .beat_q    (beat_q),
    .line_next (fill_line)
  );

  // Stalls (resp_i low) simply leave every register untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      read_reg  <= 1'b0;
      write_reg <= 1'b0;
      resp_reg  <= 1'b0;
      line_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (write_i) begin
            state_reg <= WR_BURST;
            write_reg <= 1'b1;
            addr_reg  <= aligned_addr;
          end else if (read_i) begin
            state_reg <= RD_BURST;
            read_reg  <= 1'b1;
            addr_reg  <= aligned_addr;
          end
        end
        RD_BURST, WR_BURST: begin
          if (resp_i) begin
            cnt_reg  <= cnt_reg + CNT_W'(1);
            addr_reg <= beat_addr;
            if (cnt_reg == LAST_BEAT) begin
              state_reg <= DONE;
              read_reg  <= 1'b0;
              write_reg <= 1'b0;
              resp_reg  <= 1'b1;
              addr_reg  <= '0;
              if (state_reg == RD_BURST) line_reg <= fill_line;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
          resp_reg  <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign line_o    = line_reg;
  assign resp_o    = resp_reg;
  assign read_o    = read_reg;
  assign write_o   = write_reg;
  assign address_o = addr_reg;
  assign burst_o   = write_reg ? beat_q : '0;

endmodule
